// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : display_scan_ctrl
// Brief   : NDIG-digit multiplexed 7-segment scan with blanking and
//           frame-synchronous value commit.
// Revision: 1.0
// ============================================================================
module display_scan_ctrl #(
  parameter int NDIG        = 2,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              lz_en,
  input  logic              val_valid,
  input  logic [4*NDIG-1:0] val_data,
  output logic              val_ready,
  output logic [3:0]        digit_o,
  output logic [NDIG-1:0]   an_o,
  output logic              frame_tick
);

  localparam int               CNT_W       = $clog2(REFRESH_DIV);
  localparam int               IDX_W       = $clog2(NDIG);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] C_BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] C_IDX_MAX   = IDX_W'(NDIG - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [4*NDIG-1:0] disp_q, disp_d;
  logic [4*NDIG-1:0] pend_q, pend_d;
  logic              pending_q, pending_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [3:0]        digit_q, digit_d;
  logic              tick_q, tick_d;

  logic              w_wrap;
  logic              w_boundary;
  logic              w_accept;
  logic              w_run_zero;
  logic [NDIG-1:0]   w_lz_blank;

  always_comb begin
    w_wrap     = (cnt_q == C_CNT_MAX);
    w_boundary = w_wrap && (idx_q == C_IDX_MAX);
    w_accept   = val_valid & ~pending_q;

    cnt_d   = cnt_q;
    idx_d   = idx_q;
    state_d = state_q;
    if (!en) begin
      cnt_d   = '0;
      idx_d   = '0;
      state_d = ST_BLANK;
    end else begin
      if (w_wrap) begin
        cnt_d = '0;
        idx_d = (idx_q == C_IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_BLANK: if (cnt_d == C_BLANK_END) state_d = ST_SHOW;
        ST_SHOW:  if (w_wrap)               state_d = ST_BLANK;
        default:                            state_d = ST_BLANK;
      endcase
    end

    // Commit only at the frame boundary so a frame never mixes old and new digits.
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (pending_q && w_boundary) begin
      disp_d    = pend_q;
      pending_d = 1'b0;
    end else if (w_accept) begin
      pend_d    = val_data;
      pending_d = 1'b1;
    end

    // Outputs are registered from next-state values, so evaluate against disp_d.
    w_lz_blank = '0;
    w_run_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      w_run_zero    = w_run_zero & (disp_d[4*k +: 4] == 4'd0);
      w_lz_blank[k] = lz_en & w_run_zero;
    end

    an_d    = '1;
    digit_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_d == IDX_W'(k)) begin
        digit_d = disp_d[4*k +: 4];
        if (state_d == ST_SHOW && !w_lz_blank[k]) an_d[k] = 1'b0;
      end
    end

    tick_d = en && (idx_d == C_IDX_MAX) && (cnt_d == C_CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      digit_q   <= '0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
      tick_q    <= tick_d;
    end
  end

  assign val_ready  = ~pending_q;
  assign an_o       = an_q;
  assign digit_o    = digit_q;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_display_scan_ctrl
// Brief   : Scoreboard bench for display_scan_ctrl (NDIG=2, REFRESH_DIV=8,
//           BLANK_CYC=2); expected per-cycle outputs queued, monitor compares.
// Revision: 1.0
// ============================================================================
module tb_display_scan_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       en        = 1'b0;
  logic       lz_en     = 1'b0;
  logic       val_valid = 1'b0;
  logic [7:0] val_data  = 8'h00;
  logic       val_ready;
  logic [3:0] digit_o;
  logic [1:0] an_o;
  logic       frame_tick;

  display_scan_ctrl #(
    .NDIG        (2),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .lz_en      (lz_en),
    .val_valid  (val_valid),
    .val_data   (val_data),
    .val_ready  (val_ready),
    .digit_o    (digit_o),
    .an_o       (an_o),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] an;
    logic [3:0] dig;
    logic       tick;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  // Expected outputs for scan position s of a free-running 16-cycle frame.
  function automatic exp_t scan_exp(input int s, input logic [7:0] disp,
                                    input logic lz, input logic rdy);
    exp_t e;
    int   cnt;
    int   slot;
    cnt  = s % 8;
    slot = (s / 8) % 2;
    e.an = 2'b11;
    if (cnt >= 2) e.an = (slot == 1) ? 2'b01 : 2'b10;
    if (lz && slot == 1 && disp[7:4] == 4'h0) e.an = 2'b11;
    e.dig  = (slot == 1) ? disp[7:4] : disp[3:0];
    e.tick = (slot == 1) && (cnt == 7);
    e.rdy  = rdy;
    return e;
  endfunction

  function automatic exp_t fixed_exp(input logic [1:0] an, input logic [3:0] dig,
                                     input logic rdy);
    exp_t e;
    e.an   = an;
    e.dig  = dig;
    e.tick = 1'b0;
    e.rdy  = rdy;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("an_o",       int'(an_o),       int'(mon_e.an));
      check("digit_o",    int'(digit_o),    int'(mon_e.dig));
      check("frame_tick", int'(frame_tick), int'(mon_e.tick));
      check("val_ready",  int'(val_ready),  int'(mon_e.rdy));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] disp;
    logic       rdy;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(fixed_exp(2'b11, 4'h0, 1'b1));
    rst_n = 1'b1;
    en    = 1'b1;

    // Frames 0..4: 0x42 then 0x13 back-to-back, then 0x07 and 0x00 with lz_en.
    for (int c = 0; c < 80; c++) begin
      val_valid = (c >= 3 && c <= 16) || c == 40 || c == 48;
      val_data  = (c == 3) ? 8'h42 : (c == 40) ? 8'h07 : (c == 48) ? 8'h00 : 8'h13;
      lz_en     = (c >= 40);
      rdy  = (c <= 3) || c == 16 || (c >= 32 && c <= 40) || c == 48 || c >= 64;
      disp = (c < 16) ? 8'h00 : (c < 32) ? 8'h42 : (c < 48) ? 8'h13 :
             (c < 64) ? 8'h07 : 8'h00;
      step(scan_exp(c, disp, c >= 41, rdy));
    end

    // Accept 0x55, then drop en mid-slot; commit waits for a real boundary.
    lz_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      val_valid = (c == 0);
      val_data  = 8'h55;
      en        = (c < 3);
      if (c <= 3) step(scan_exp(c, 8'h00, 1'b0, c == 0));
      else        step(fixed_exp(2'b11, 4'h0, 1'b0));
    end
    en        = 1'b1;
    val_valid = 1'b0;
    for (int s = 0; s < 32; s++)
      step(scan_exp(s, (s < 16) ? 8'h00 : 8'h55, 1'b0, s >= 16));

    // 0x99 pending, then reset mid-SHOW of digit 1.
    for (int s = 0; s < 11; s++) begin
      val_valid = (s == 0);
      val_data  = 8'h99;
      step(scan_exp(s, 8'h55, 1'b0, s == 0));
    end
    val_valid = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < 2; i++) step(fixed_exp(2'b11, 4'h0, 1'b1));
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) step(scan_exp(c, 8'h00, 1'b0, 1'b1));

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
